stage1_pipelined_mult: RTL and testbench



---
 rtl/stage1_pipelined_mult_pkg.sv | 45 ++++
 rtl/stage1_pipelined_mult_pipe_reg.sv | 27 ++
 rtl/stage1_pipelined_mult.sv | 91 +++++++++
 tb/tb_stage1_pipelined_mult.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/stage1_pipelined_mult_pkg.sv
// rtl/stage1_pipelined_mult_pkg.sv - shared widths, weight constants and weight-index encoding
package stage1_pipelined_mult_pkg;

  localparam int A_WIDTH_DEF = 9;
  localparam int B_WIDTH_DEF = 12;
  localparam int P_WIDTH_DEF = 24;

  // B is split into a signed upper part and this many unsigned low bits
  localparam int SPLIT_LSBS = 6;

  localparam logic signed [B_WIDTH_DEF-1:0] W_M21   = -12'sd21;
  localparam logic signed [B_WIDTH_DEF-1:0] W_M135  = -12'sd135;
  localparam logic signed [B_WIDTH_DEF-1:0] W_M147  = -12'sd147;
  localparam logic signed [B_WIDTH_DEF-1:0] W_M225  = -12'sd225;
  localparam logic signed [B_WIDTH_DEF-1:0] W_P235  = 12'sd235;
  localparam logic signed [B_WIDTH_DEF-1:0] W_P873  = 12'sd873;
  localparam logic signed [B_WIDTH_DEF-1:0] W_P1535 = 12'sd1535;
  localparam logic signed [B_WIDTH_DEF-1:0] W_P1981 = 12'sd1981;

  typedef enum logic [2:0] {
    WI_M21   = 3'd0,
    WI_M135  = 3'd1,
    WI_M147  = 3'd2,
    WI_M225  = 3'd3,
    WI_P235  = 3'd4,
    WI_P873  = 3'd5,
    WI_P1535 = 3'd6,
    WI_P1981 = 3'd7
  } weight_idx_e;

  // Map a 3-bit weight index to its bicubic coefficient
  function automatic logic signed [B_WIDTH_DEF-1:0] weight_of(input weight_idx_e idx);
    case (idx)
      WI_M21:   weight_of = W_M21;
      WI_M135:  weight_of = W_M135;
      WI_M147:  weight_of = W_M147;
      WI_M225:  weight_of = W_M225;
      WI_P235:  weight_of = W_P235;
      WI_P873:  weight_of = W_P873;
      WI_P1535: weight_of = W_P1535;
      default:  weight_of = W_P1981;
    endcase
  endfunction

endpackage

// File: rtl/stage1_pipelined_mult_pipe_reg.sv
// rtl/stage1_pipelined_mult_pipe_reg.sv - CE-gated pipeline register with async clear
module mult_pipe_reg
  import stage1_pipelined_mult_pkg::*;
#(
  parameter int WIDTH = A_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Load on enabled edges, hold otherwise, clear immediately on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (ce_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/stage1_pipelined_mult.sv
// rtl/stage1_pipelined_mult.sv - signed 9x12 bicubic weight multiplier, latency 1/2/3
module stage1_pipelined_mult
  import stage1_pipelined_mult_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = P_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic signed [A_WIDTH-1:0] A,
  input  logic signed [B_WIDTH-1:0] B,
  input  logic                      CE,
  output logic signed [P_WIDTH-1:0] P
);

  localparam int SPLIT = SPLIT_LSBS;

  // Reject configurations that cannot produce an exact product
  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("stage1_pipelined_mult: LATENCY must be 1, 2 or 3");
  end
  if (P_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_pwidth
    $error("stage1_pipelined_mult: P_WIDTH must be >= A_WIDTH + B_WIDTH");
  end
  if (B_WIDTH <= SPLIT) begin : g_bad_bwidth
    $error("stage1_pipelined_mult: B_WIDTH too narrow for partial-product split");
  end

  if (LATENCY == 1) begin : g_lat1
    logic signed [P_WIDTH-1:0] p_d;
    // Operands are widened first so the product is exact and sign-extended
    assign p_d = P_WIDTH'(A) * P_WIDTH'(B);
    mult_pipe_reg #(.WIDTH(P_WIDTH)) u_p_reg (
      .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .d_i(p_d), .q_o(P)
    );
  end else if (LATENCY == 2) begin : g_lat2
    logic signed [A_WIDTH-1:0] a_q;
    logic signed [B_WIDTH-1:0] b_q;
    logic signed [P_WIDTH-1:0] p_d;
    mult_pipe_reg #(.WIDTH(A_WIDTH)) u_a_reg (
      .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .d_i(A), .q_o(a_q)
    );
    mult_pipe_reg #(.WIDTH(B_WIDTH)) u_b_reg (
      .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .d_i(B), .q_o(b_q)
    );
    assign p_d = P_WIDTH'(a_q) * P_WIDTH'(b_q);
    mult_pipe_reg #(.WIDTH(P_WIDTH)) u_p_reg (
      .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .d_i(p_d), .q_o(P)
    );
  end else begin : g_lat3
    // A*B = A*signed(B_hi)*2^SPLIT + A*unsigned(B_lo); each part is exact at its width
    localparam int HI_W = A_WIDTH + B_WIDTH - SPLIT;
    localparam int LO_W = A_WIDTH + SPLIT + 1;
    logic signed [A_WIDTH-1:0]       a_q;
    logic signed [B_WIDTH-1:0]       b_q;
    logic signed [B_WIDTH-SPLIT-1:0] b_hi;
    logic signed [SPLIT:0]           b_lo;
    logic signed [HI_W-1:0]          pp_hi_d;
    logic signed [HI_W-1:0]          pp_hi_q;
    logic signed [LO_W-1:0]          pp_lo_d;
    logic signed [LO_W-1:0]          pp_lo_q;
    logic signed [P_WIDTH-1:0]       p_d;

    mult_pipe_reg #(.WIDTH(A_WIDTH)) u_a_reg (
      .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .d_i(A), .q_o(a_q)
    );
    mult_pipe_reg #(.WIDTH(B_WIDTH)) u_b_reg (
      .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .d_i(B), .q_o(b_q)
    );

    assign b_hi    = b_q[B_WIDTH-1:SPLIT];
    assign b_lo    = {1'b0, b_q[SPLIT-1:0]};
    assign pp_hi_d = HI_W'(a_q) * HI_W'(b_hi);
    assign pp_lo_d = LO_W'(a_q) * LO_W'(b_lo);

    mult_pipe_reg #(.WIDTH(HI_W)) u_pp_hi_reg (
      .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .d_i(pp_hi_d), .q_o(pp_hi_q)
    );
    mult_pipe_reg #(.WIDTH(LO_W)) u_pp_lo_reg (
      .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .d_i(pp_lo_d), .q_o(pp_lo_q)
    );

    assign p_d = (P_WIDTH'(pp_hi_q) <<< SPLIT) + P_WIDTH'(pp_lo_q);
    mult_pipe_reg #(.WIDTH(P_WIDTH)) u_p_reg (
      .clk_i(CLK), .rst_ni(RST_N), .ce_i(CE), .d_i(p_d), .q_o(P)
    );
  end

endmodule

// File: tb/tb_stage1_pipelined_mult.sv
// tb/tb_stage1_pipelined_mult.sv - self-checking bench for all three latency variants
module tb_stage1_pipelined_mult;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ce;
  logic signed [8:0]  a;
  logic signed [11:0] b;
  logic signed [23:0] p1, p2, p3;

  always #5 clk = ~clk;

  stage1_pipelined_mult #(.LATENCY(1)) u_dut1 (.CLK(clk), .RST_N(rst_n), .A(a), .B(b), .CE(ce), .P(p1));
  stage1_pipelined_mult #(.LATENCY(2)) u_dut2 (.CLK(clk), .RST_N(rst_n), .A(a), .B(b), .CE(ce), .P(p2));
  stage1_pipelined_mult #(.LATENCY(3)) u_dut3 (.CLK(clk), .RST_N(rst_n), .A(a), .B(b), .CE(ce), .P(p3));

  typedef struct {
    int av;
    int bv;
    int pv;
  } vec_t;

  vec_t vecs[6];
  int   weights[8];

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboards: one queue per latency, preloaded with the zeros sitting in the cleared pipe
  int q1[$];
  int q2[$];
  int q3[$];
  int e1, e2, e3;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    q3.delete();
    q2.push_back(0);
    q3.push_back(0);
    q3.push_back(0);
    e1 = 0;
    e2 = 0;
    e3 = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, " L1"}, p1, e1);
    check({tag, " L2"}, p2, e2);
    check({tag, " L3"}, p3, e3);
  endtask

  // Drive one operand pair, take one clock edge, then compare every latency variant
  task automatic step(input int av, input int bv, input bit cev, input string tag);
    int pr;
    a  = 9'(av);
    b  = 12'(bv);
    ce = cev;
    @(posedge clk);
    if (cev) begin
      pr = av * bv;
      q1.push_back(pr);
      q2.push_back(pr);
      q3.push_back(pr);
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      e3 = q3.pop_front();
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    weights = '{-21, -135, -147, -225, 235, 873, 1535, 1981};
    vecs[0] = '{255,  -135,  -34425};
    vecs[1] = '{-256, 1981,  -507136};
    vecs[2] = '{-256, -21,   5376};
    vecs[3] = '{255,  2047,  521985};
    vecs[4] = '{-256, -2048, 524288};
    vecs[5] = '{-1,   1,     -1};

    rst_n = 1'b0;
    ce    = 1'b1;
    a     = '0;
    b     = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release with CE low must not load anything
    step(5, 235, 1'b0, "ce0_after_rst");

    // Directed vectors held for three edges, compared against fixed products
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) step(vecs[i].av, vecs[i].bv, 1'b1, "table_seq");
      check("table L1", p1, vecs[i].pv);
      check("table L2", p2, vecs[i].pv);
      check("table L3", p3, vecs[i].pv);
    end

    // Back-to-back stream cycling all weights
    for (int i = 0; i < 256; i++) step(i, weights[i % 8], 1'b1, "stream");

    // Stream with pseudo-random CE stalls
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 511) - 256, weights[$urandom_range(0, 7)],
           $urandom_range(0, 2) != 0, "ce_stall");
    end

    // Asynchronous reset between edges while the pipe is full
    for (int i = 0; i < 4; i++) step(100 + i, weights[i], 1'b1, "prefill");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
    step(-200, 873, 1'b1, "post_rst");
    check("first_after_rst L1", p1, -174600);
    step(17, -147, 1'b1, "post_rst");
    check("first_after_rst L2", p2, -174600);
    step(3, 1535, 1'b1, "post_rst");
    check("first_after_rst L3", p3, -174600);

    // Exhaustive A against every weight
    for (int av = -256; av < 256; av++) begin
      for (int w = 0; w < 8; w++) step(av, weights[w], 1'b1, "exhaustive");
    end
    for (int k = 0; k < 3; k++) step(0, 0, 1'b1, "flush");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
